conv_stream_loader: RTL and testbench
=====================================

CONV_STREAM_LOADER -- requirements
Module: conv_stream_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, sample width written into the X/Y input memories.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, input-memory address width; the maximum sequence length is 2^ADDR_WIDTH-1.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_a  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports s_data_i  input  DATA_WIDTH; s_valid_i  input  1; s_last_i  input  1; s_ready_o  output  1: sample stream, X samples then Y samples.
REQ-006 SHALL have ports lenX_i and lenY_i  input  ADDR_WIDTH each: sequence lengths, sampled on go_i.
REQ-007 SHALL have port go_i  input  1  one-cycle request to begin a load.
REQ-008 SHALL have ports memX_wr_o  output  1; memX_addr_o  output  ADDR_WIDTH; memX_data_o  output  DATA_WIDTH; and the identical memY_* set.
REQ-009 SHALL have port config_o  output  32  [4:0]=lenX, [9:5]=lenY, remaining bits 0; this is the convolution configuration word.
REQ-010 SHALL have ports start_o  output  1 (core start pulse), core_done_i  input  1, busy_o  output  1, done_o  output  1, err_o  output  1.

Function
REQ-011 SHALL implement FSM states IDLE, LOAD_X, LOAD_Y, START, WAIT_CORE.
REQ-012 In IDLE, go_i with both lengths nonzero SHALL latch the lengths into config_o, clear err_o, zero the beat counter, and enter LOAD_X on the next cycle.
REQ-013 In IDLE, go_i with lenX_i=0 or lenY_i=0 SHALL set err_o and remain in IDLE.
REQ-014 s_ready_o SHALL be 1 only in LOAD_X and LOAD_Y; a beat is accepted when s_valid_i and s_ready_o are both 1.
REQ-015 Each accepted beat SHALL produce a registered one-cycle write, one cycle after acceptance, at the current counter address; the counter then increments.
REQ-016 Accepting beat lenX-1 in LOAD_X SHALL reset the counter to 0 and enter LOAD_Y.
REQ-017 Accepting beat lenY-1 in LOAD_Y SHALL enter START; if s_last_i is 0 on that beat, err_o SHALL be set and the flow SHALL continue.
REQ-018 s_last_i=1 on any earlier accepted beat SHALL abort: set err_o, write that beat, return to IDLE, and issue no start_o.
REQ-019 START SHALL last one cycle; start_o SHALL be 1 there, which is one cycle after the final memY write.
REQ-020 In WAIT_CORE, core_done_i SHALL produce done_o=1 for one cycle and a return to IDLE.
REQ-021 busy_o SHALL be 1 in every state except IDLE.
REQ-022 go_i outside IDLE SHALL be ignored.
REQ-023 The address counter SHALL never wrap, because lengths are bounded by ADDR_WIDTH.

Reset
REQ-024 rst_a SHALL force IDLE immediately at any time, including mid-load, and SHALL set every output to 0, including config_o; s_ready_o SHALL be 0.
REQ-025 Memory contents are not cleared by reset; a new load SHALL overwrite them.

Configuration
REQ-026 With CONV_LOADER_AUTOSTART_EN defined, START SHALL be entered as specified in REQ-017.
REQ-027 Without CONV_LOADER_AUTOSTART_EN, the FSM SHALL hold in an extra state ARMED after the final beat, and go_i in ARMED SHALL enter START.

Structure
REQ-028 Package conv_loader_pkg SHALL hold the FSM state enum, the DATA_WIDTH/ADDR_WIDTH defaults and the config_o bit-field offsets (X at 0, Y at 5).
REQ-029 Sub-module conv_beat_counter SHALL be used: a loadable, clearable ADDR_WIDTH counter with terminal-count compare.

Verification
REQ-030 lenX=3, lenY=2, stream 1,2,3,4,5 with last on 5 -> memX[0..2]=1,2,3, memY[0..1]=4,5, config_o=0x43, one start_o pulse, core_done_i -> one done_o pulse.
REQ-031 Random s_valid_i gaps (50%) with lenX=31, lenY=31 -> all 62 writes in order, addresses 0..30, no extra writes.
REQ-032 s_last_i on X beat 1 of 4 -> err_o=1, IDLE, start_o never asserted.
REQ-033 go_i with lenY=0 -> err_o=1, busy_o stays 0.
REQ-034 rst_a asserted mid LOAD_Y -> all outputs 0 in the same cycle; a following full load of lenX=2, lenY=2 completes correctly.
REQ-035 Build without CONV_LOADER_AUTOSTART_EN -> after the final beat no start_o until go_i; start_o follows one cycle after go_i.

Source files
------------

// File: rtl/conv_loader_pkg.sv
// Shared types and constants for the convolution stream loader:
// FSM state encoding, width defaults and config word field offsets.
package conv_loader_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 5;

  localparam int CFG_X_OFS = 0;
  localparam int CFG_Y_OFS = 5;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_X,
    LOAD_Y,
    ARMED,
    START,
    WAIT_CORE
  } state_t;

endpackage

// File: rtl/conv_beat_counter.sv
// Beat/address counter: clear has priority over load, load over increment;
// o_tc flags that the current count equals the terminal value.
module conv_beat_counter #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_a,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_inc,
  input  logic [WIDTH-1:0] i_term,
  output logic [WIDTH-1:0] o_count,
  output logic             o_tc
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_inc) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == i_term);

endmodule

// File: rtl/conv_stream_loader.sv
// Loads an X-then-Y sample stream into two input memories and starts the core.
// Build option CONV_LOADER_AUTOSTART_EN: start the core without waiting for go_i in ARMED.
module conv_stream_loader
  import conv_loader_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_a,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_valid_i,
  input  logic                  s_last_i,
  output logic                  s_ready_o,
  input  logic [ADDR_WIDTH-1:0] lenX_i,
  input  logic [ADDR_WIDTH-1:0] lenY_i,
  input  logic                  go_i,
  output logic                  memX_wr_o,
  output logic [ADDR_WIDTH-1:0] memX_addr_o,
  output logic [DATA_WIDTH-1:0] memX_data_o,
  output logic                  memY_wr_o,
  output logic [ADDR_WIDTH-1:0] memY_addr_o,
  output logic [DATA_WIDTH-1:0] memY_data_o,
  output logic [31:0]           config_o,
  output logic                  start_o,
  input  logic                  core_done_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_len_x;
  logic [ADDR_WIDTH-1:0] r_len_y;
  logic [31:0]           r_config;
  logic                  r_err;
  logic                  r_done;
  logic                  r_x_wr;
  logic [ADDR_WIDTH-1:0] r_x_addr;
  logic [DATA_WIDTH-1:0] r_x_data;
  logic                  r_y_wr;
  logic [ADDR_WIDTH-1:0] r_y_addr;
  logic [DATA_WIDTH-1:0] r_y_data;

  logic                  w_ready;
  logic                  w_accept;
  logic                  w_go_ok;
  logic                  w_go_bad;
  logic                  w_final_x;
  logic                  w_final_y;
  logic                  w_abort;
  logic                  w_cnt_clr;
  logic                  w_tc;
  logic [ADDR_WIDTH-1:0] w_count;
  logic [ADDR_WIDTH-1:0] w_term;

  assign w_ready   = (r_state == LOAD_X) || (r_state == LOAD_Y);
  assign w_accept  = s_valid_i && w_ready;
  assign w_go_ok   = (r_state == IDLE) && go_i && (lenX_i != '0) && (lenY_i != '0);
  assign w_go_bad  = (r_state == IDLE) && go_i && ((lenX_i == '0) || (lenY_i == '0));
  assign w_final_x = w_accept && (r_state == LOAD_X) && w_tc;
  assign w_final_y = w_accept && (r_state == LOAD_Y) && w_tc;
  // s_last_i anywhere but on the last Y beat cuts the load short
  assign w_abort   = w_accept && s_last_i && !w_final_y;
  assign w_cnt_clr = w_go_ok || w_final_x;
  assign w_term    = (r_state == LOAD_Y) ? (r_len_y - ADDR_WIDTH'(1))
                                         : (r_len_x - ADDR_WIDTH'(1));

  conv_beat_counter #(
    .WIDTH(ADDR_WIDTH)
  ) u_beat_counter (
    .clk       (clk),
    .rst_a     (rst_a),
    .i_clr     (w_cnt_clr),
    .i_load    (1'b0),
    .i_load_val({ADDR_WIDTH{1'b0}}),
    .i_inc     (w_accept),
    .i_term    (w_term),
    .o_count   (w_count),
    .o_tc      (w_tc)
  );

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ARMED always follows the last Y beat so start_o lands one cycle after that write
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_go_ok) w_state_nxt = LOAD_X;
      end
      LOAD_X: begin
        if (w_accept) begin
          if (s_last_i)  w_state_nxt = IDLE;
          else if (w_tc) w_state_nxt = LOAD_Y;
        end
      end
      LOAD_Y: begin
        if (w_accept) begin
          if (w_tc)          w_state_nxt = ARMED;
          else if (s_last_i) w_state_nxt = IDLE;
        end
      end
      ARMED: begin
`ifdef CONV_LOADER_AUTOSTART_EN
        w_state_nxt = START;
`else
        if (go_i) w_state_nxt = START;
`endif
      end
      START: begin
        w_state_nxt = WAIT_CORE;
      end
      WAIT_CORE: begin
        if (core_done_i) w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      r_len_x  <= '0;
      r_len_y  <= '0;
      r_config <= '0;
      r_err    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      if (w_go_ok) begin
        r_len_x  <= lenX_i;
        r_len_y  <= lenY_i;
        r_config <= (32'(lenX_i) << CFG_X_OFS) | (32'(lenY_i) << CFG_Y_OFS);
      end
      if (w_go_ok) begin
        r_err <= 1'b0;
      end else if (w_go_bad || w_abort || (w_final_y && !s_last_i)) begin
        r_err <= 1'b1;
      end
      r_done <= (r_state == WAIT_CORE) && core_done_i;
    end
  end

  // write stage: one registered strobe per accepted beat at the pre-increment address
  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      r_x_wr   <= 1'b0;
      r_x_addr <= '0;
      r_x_data <= '0;
      r_y_wr   <= 1'b0;
      r_y_addr <= '0;
      r_y_data <= '0;
    end else begin
      r_x_wr <= w_accept && (r_state == LOAD_X);
      r_y_wr <= w_accept && (r_state == LOAD_Y);
      if (w_accept && (r_state == LOAD_X)) begin
        r_x_addr <= w_count;
        r_x_data <= s_data_i;
      end
      if (w_accept && (r_state == LOAD_Y)) begin
        r_y_addr <= w_count;
        r_y_data <= s_data_i;
      end
    end
  end

  assign s_ready_o   = w_ready;
  assign memX_wr_o   = r_x_wr;
  assign memX_addr_o = r_x_addr;
  assign memX_data_o = r_x_data;
  assign memY_wr_o   = r_y_wr;
  assign memY_addr_o = r_y_addr;
  assign memY_data_o = r_y_data;
  assign config_o    = r_config;
  assign start_o     = (r_state == START);
  assign busy_o      = (r_state != IDLE);
  assign done_o      = r_done;
  assign err_o       = r_err;

endmodule

// File: tb/tb_conv_stream_loader.sv
// Randomized bench for conv_stream_loader with a stream-level reference model
// (expected write queues, error and start outcome per load).
module tb_conv_stream_loader;

  localparam int DW = 8;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_a = 1'b0;
  logic [DW-1:0] s_data_i = '0;
  logic          s_valid_i = 1'b0;
  logic          s_last_i = 1'b0;
  logic          s_ready_o;
  logic [AW-1:0] lenX_i = '0;
  logic [AW-1:0] lenY_i = '0;
  logic          go_i = 1'b0;
  logic          memX_wr_o;
  logic [AW-1:0] memX_addr_o;
  logic [DW-1:0] memX_data_o;
  logic          memY_wr_o;
  logic [AW-1:0] memY_addr_o;
  logic [DW-1:0] memY_data_o;
  logic [31:0]   config_o;
  logic          start_o;
  logic          core_done_i = 1'b0;
  logic          busy_o;
  logic          done_o;
  logic          err_o;

  conv_stream_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_a(rst_a),
    .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_last_i(s_last_i), .s_ready_o(s_ready_o),
    .lenX_i(lenX_i), .lenY_i(lenY_i), .go_i(go_i),
    .memX_wr_o(memX_wr_o), .memX_addr_o(memX_addr_o), .memX_data_o(memX_data_o),
    .memY_wr_o(memY_wr_o), .memY_addr_o(memY_addr_o), .memY_data_o(memY_data_o),
    .config_o(config_o), .start_o(start_o), .core_done_i(core_done_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int qx_addr[$];
  int qx_data[$];
  int qy_addr[$];
  int qy_data[$];
  int stim_dat[64];
  bit stim_lst[64];
  logic [DW-1:0] memx[32];
  logic [DW-1:0] memy[32];
  int n_start = 0;
  int n_done = 0;
  int last_y_wr_cyc = -1;
  int start_cyc = -1;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // per-cycle scoreboard on the memory write ports plus start/done accounting
  initial forever begin
    @(negedge clk);
    if (mon_en && !rst_a) begin
      if (memX_wr_o) begin
        memx[memX_addr_o] = memX_data_o;
        if (qx_addr.size() == 0) chk("memX_extra_write", 1, 0);
        else begin
          chk("memX_addr", 64'(memX_addr_o), 64'(qx_addr.pop_front()));
          chk("memX_data", 64'(memX_data_o), 64'(qx_data.pop_front()));
        end
      end
      if (memY_wr_o) begin
        memy[memY_addr_o] = memY_data_o;
        last_y_wr_cyc = cyc;
        if (qy_addr.size() == 0) chk("memY_extra_write", 1, 0);
        else begin
          chk("memY_addr", 64'(memY_addr_o), 64'(qy_addr.pop_front()));
          chk("memY_data", 64'(memY_data_o), 64'(qy_data.pop_front()));
        end
      end
      if (start_o) begin
        n_start++;
        start_cyc = cyc;
      end
      if (done_o) n_done++;
    end
  end

  // Stream-level reference: beat i goes to X[i] or Y[i-lx]; an early last ends the load.
  task automatic model_job(input int lx, input int ly, output int nsend, output bit e_err,
                           output bit e_start);
    nsend = 0;
    e_err = 1'b0;
    e_start = 1'b0;
    for (int i = 0; i < lx + ly; i++) begin
      nsend++;
      if (i < lx) begin
        qx_addr.push_back(i);
        qx_data.push_back(stim_dat[i] & 8'hff);
      end else begin
        qy_addr.push_back(i - lx);
        qy_data.push_back(stim_dat[i] & 8'hff);
      end
      if (i == lx + ly - 1) begin
        e_err = !stim_lst[i];
        e_start = 1'b1;
      end else if (stim_lst[i]) begin
        e_err = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_s_ready"}, 64'(s_ready_o), 0);
    chk({tag, "_memX_wr"}, 64'(memX_wr_o), 0);
    chk({tag, "_memX_addr"}, 64'(memX_addr_o), 0);
    chk({tag, "_memX_data"}, 64'(memX_data_o), 0);
    chk({tag, "_memY_wr"}, 64'(memY_wr_o), 0);
    chk({tag, "_memY_addr"}, 64'(memY_addr_o), 0);
    chk({tag, "_memY_data"}, 64'(memY_data_o), 0);
    chk({tag, "_config"}, 64'(config_o), 0);
    chk({tag, "_start"}, 64'(start_o), 0);
    chk({tag, "_busy"}, 64'(busy_o), 0);
    chk({tag, "_done"}, 64'(done_o), 0);
    chk({tag, "_err"}, 64'(err_o), 0);
  endtask

  task automatic run_job(input int lx, input int ly, input int gap, input string tag,
                         input int stop_at);
    int nsend, sent, budget, s0, d0, gcyc;
    bit e_err, e_start, acc;
    logic [31:0] exp_cfg;
    model_job(lx, ly, nsend, e_err, e_start);
    if (stop_at > 0 && stop_at < nsend) nsend = stop_at;
    exp_cfg = 32'(lx) | (32'(ly) << 5);
    s0 = n_start;
    d0 = n_done;
    @(negedge clk);
    lenX_i = AW'(lx);
    lenY_i = AW'(ly);
    go_i = 1'b1;
    @(negedge clk);
    go_i = 1'b0;
    lenX_i = AW'($urandom);
    lenY_i = AW'($urandom);
    chk({tag, "_busy_after_go"}, 64'(busy_o), 1);
    chk({tag, "_config"}, 64'(config_o), 64'(exp_cfg));
    chk({tag, "_err_cleared"}, 64'(err_o), 0);
    sent = 0;
    budget = 4000;
    while (sent < nsend && budget > 0) begin
      s_valid_i = ($urandom_range(99) >= gap);
      s_data_i = DW'(stim_dat[sent]);
      s_last_i = stim_lst[sent];
      go_i = ($urandom_range(7) == 0);
      acc = s_valid_i && s_ready_o;
      @(negedge clk);
      if (acc) sent++;
      budget--;
    end
    s_valid_i = 1'b0;
    s_last_i = 1'b0;
    go_i = 1'b0;
    s_data_i = DW'($urandom);
    if (budget == 0) chk({tag, "_stream_timeout"}, 0, 1);
    if (stop_at > 0) return;
    if (e_start) begin
`ifndef CONV_LOADER_AUTOSTART_EN
      repeat (3) @(negedge clk);
      #1;
      chk({tag, "_no_start_before_go"}, 64'(n_start - s0), 0);
      chk({tag, "_busy_armed"}, 64'(busy_o), 1);
      gcyc = cyc;
      go_i = 1'b1;
      @(negedge clk);
      go_i = 1'b0;
      @(negedge clk);
      #1;
      chk({tag, "_start_count"}, 64'(n_start - s0), 1);
      chk({tag, "_start_after_go"}, 64'(start_cyc), 64'(gcyc + 1));
`else
      repeat (3) @(negedge clk);
      #1;
      chk({tag, "_start_count"}, 64'(n_start - s0), 1);
      chk({tag, "_start_after_write"}, 64'(start_cyc), 64'(last_y_wr_cyc + 1));
`endif
      repeat ($urandom_range(3)) @(negedge clk);
      #1;
      chk({tag, "_busy_wait_core"}, 64'(busy_o), 1);
      chk({tag, "_no_early_done"}, 64'(n_done - d0), 0);
      core_done_i = 1'b1;
      @(negedge clk);
      core_done_i = 1'b0;
      @(negedge clk);
      #1;
      chk({tag, "_done_count"}, 64'(n_done - d0), 1);
      chk({tag, "_idle_after_done"}, 64'(busy_o), 0);
    end else begin
      repeat (3) @(negedge clk);
      #1;
      chk({tag, "_abort_idle"}, 64'(busy_o), 0);
      chk({tag, "_abort_no_start"}, 64'(n_start - s0), 0);
    end
    chk({tag, "_err"}, 64'(err_o), 64'(e_err));
    chk({tag, "_x_writes_missing"}, 64'(qx_addr.size()), 0);
    chk({tag, "_y_writes_missing"}, 64'(qy_addr.size()), 0);
    chk({tag, "_config_hold"}, 64'(config_o), 64'(exp_cfg));
  endtask

  task automatic fill_random(input int n, input int last_idx);
    for (int i = 0; i < 64; i++) begin
      stim_dat[i] = int'($urandom_range(255));
      stim_lst[i] = 1'b0;
    end
    if (last_idx >= 0 && last_idx < n) stim_lst[last_idx] = 1'b1;
  endtask

  initial begin
    #50000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nsend, lx, ly, li;
    bit e_err, e_start;

    #2 rst_a = 1'b1;
    #1 check_zero("reset");
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // lenX=3, lenY=2, stream 1..5, last on 5
    fill_random(5, 4);
    for (int i = 0; i < 5; i++) stim_dat[i] = i + 1;
    run_job(3, 2, 0, "basic", 0);
    chk("basic_cfg_literal", 64'(config_o), 64'h43);
    chk("basic_memx0", 64'(memx[0]), 1);
    chk("basic_memx1", 64'(memx[1]), 2);
    chk("basic_memx2", 64'(memx[2]), 3);
    chk("basic_memy0", 64'(memy[0]), 4);
    chk("basic_memy1", 64'(memy[1]), 5);
    chk("basic_total_start", 64'(n_start), 1);
    chk("basic_total_done", 64'(n_done), 1);

    // zero length request
    @(negedge clk);
    lenX_i = 5'd3;
    lenY_i = 5'd0;
    go_i = 1'b1;
    @(negedge clk);
    go_i = 1'b0;
    #1;
    chk("zero_len_err", 64'(err_o), 1);
    chk("zero_len_busy", 64'(busy_o), 0);
    repeat (3) @(negedge clk);
    chk("zero_len_busy_later", 64'(busy_o), 0);
    chk("zero_len_ready", 64'(s_ready_o), 0);
    chk("zero_len_cfg_kept", 64'(config_o), 64'h43);

    // early last on X beat 1 of 4; pin the model's verdict first
    fill_random(6, 1);
    model_job(4, 2, nsend, e_err, e_start);
    chk("model_abort_beats", 64'(nsend), 2);
    chk("model_abort_err", 64'(e_err), 1);
    chk("model_abort_start", 64'(e_start), 0);
    chk("model_abort_xq", 64'(qx_addr.size()), 2);
    qx_addr.delete(); qx_data.delete(); qy_addr.delete(); qy_data.delete();
    run_job(4, 2, 0, "abort_x1", 0);

    // final beat without last: error flagged, flow continues
    fill_random(5, -1);
    run_job(2, 3, 20, "no_last", 0);

    // maximum lengths with 50% valid gaps
    fill_random(62, 61);
    run_job(31, 31, 50, "max_len", 0);

    for (int k = 0; k < 10; k++) begin
      lx = int'($urandom_range(31, 1));
      ly = int'($urandom_range(31, 1));
      case ($urandom_range(3))
        0: li = int'($urandom_range(lx + ly - 1));
        1: li = -1;
        default: li = lx + ly - 1;
      endcase
      fill_random(lx + ly, li);
      run_job(lx, ly, int'($urandom_range(60)), $sformatf("rand%0d", k), 0);
    end

    // reset while in LOAD_Y with a Y write in flight
    fill_random(6, 5);
    run_job(3, 3, 0, "rst_mid", 4);
    chk("rst_mid_busy_before", 64'(busy_o), 1);
    chk("rst_mid_ywr_before", 64'(memY_wr_o), 1);
    #1 rst_a = 1'b1;
    #1 check_zero("rst_mid");
    qx_addr.delete(); qx_data.delete(); qy_addr.delete(); qy_data.delete();
    @(negedge clk);
    rst_a = 1'b0;
    fill_random(4, 3);
    run_job(2, 2, 30, "after_rst", 0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
